// File: rtl/fpu_sb_pkg.sv
// Shared defaults and per-opcode result latencies for the VLIW decode scoreboard.
// A latency is the number of extra cycles before a result can be forwarded.
package fpu_sb_pkg;

   localparam int SB_NLANES = 4;
   localparam int SB_NREG   = 64;
   localparam int SB_LAT_W  = 5;
   localparam int SB_PERF_W = 32;

   // Zero means the consumer may issue in the very next bundle.
   localparam int LAT_ALU   = 0;
   localparam int LAT_LW    = 1;
   localparam int LAT_FADD  = 1;
   localparam int LAT_FSUB  = 1;
   localparam int LAT_FMUL  = 1;
   localparam int LAT_FSQRT = 2;
   localparam int LAT_FDIV  = 3;
   localparam int LAT_OTHER = 0;

endpackage

// File: rtl/sb_countdown.sv
// One scoreboard countdown: loads a latency, then decrements by one per cycle
// until it reaches zero, where it rests.
module sb_countdown #(
   parameter int LAT_W = 5
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             load,
   input  logic [LAT_W-1:0] load_val,
   output logic [LAT_W-1:0] value,
   output logic             nonzero
);

   // A load overrides the decrement in the same cycle.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         value <= '0;
      end else if (load) begin
         value <= load_val;
      end else if (value != '0) begin
         value <= value - 1'b1;
      end
   end

   assign nonzero = (value != '0);

endmodule

// File: rtl/fpu_scoreboard_vliw.sv
// Register scoreboard and interlock for the VLIW decode stage: stalls a bundle on
// RAW, WAW and busy-unpipelined-unit hazards using per-register countdowns.
module fpu_scoreboard_vliw
   import fpu_sb_pkg::*;
#(
   parameter  int NLANES = SB_NLANES,
   parameter  int NREG   = SB_NREG,
   parameter  int LAT_W  = SB_LAT_W,
   parameter  int PERF_W = SB_PERF_W,
   localparam int REG_W  = $clog2(NREG)
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      issue_valid_i,
   input  logic                      flush_i,
   input  logic [NLANES-1:0]         lane_valid_i,
   input  logic [NLANES*2*REG_W-1:0] src_reg_i,
   input  logic [NLANES*2-1:0]       src_use_i,
   input  logic [NLANES*REG_W-1:0]   dst_reg_i,
   input  logic [NLANES-1:0]         dst_we_i,
   input  logic [NLANES*LAT_W-1:0]   lat_i,
   input  logic [NLANES-1:0]         unpipelined_i,
   output logic                      stall_o,
   output logic                      issue_o,
   output logic [NREG-1:0]           pending_o,
   output logic [PERF_W-1:0]         stall_cycles_o
);

   logic [LAT_W-1:0] cnt      [NREG];
   logic             reg_load [NREG];
   logic [LAT_W-1:0] reg_val  [NREG];
   logic [LAT_W-1:0] ucnt     [NLANES];
   logic [NLANES-1:0] ucnt_nz;
   logic [NLANES-1:0] lane_load;
   logic             raw;
   logic             waw;
   logic             strct;
   logic             bundle_live;
   logic [PERF_W-1:0] perf;

   // r0 never holds a pending result.
   assign cnt[0]       = '0;
   assign pending_o[0] = 1'b0;

   for (genvar r = 1; r < NREG; r++) begin : g_reg
      sb_countdown #(.LAT_W(LAT_W)) u_cnt (
         .clk      (clk),
         .rstn     (rstn),
         .load     (reg_load[r]),
         .load_val (reg_val[r]),
         .value    (cnt[r]),
         .nonzero  (pending_o[r])
      );
   end

   for (genvar l = 0; l < NLANES; l++) begin : g_lane
      sb_countdown #(.LAT_W(LAT_W)) u_ucnt (
         .clk      (clk),
         .rstn     (rstn),
         .load     (lane_load[l]),
         .load_val (lat_i[l*LAT_W +: LAT_W]),
         .value    (ucnt[l]),
         .nonzero  (ucnt_nz[l])
      );
   end

   // Hazards compare against pre-bundle state only, so lanes never see each other.
   always_comb begin
      raw   = 1'b0;
      waw   = 1'b0;
      strct = 1'b0;
      for (int l = 0; l < NLANES; l++) begin
         if (lane_valid_i[l]) begin
            for (int k = 0; k < 2; k++) begin
               if (src_use_i[l*2+k] && pending_o[src_reg_i[(l*2+k)*REG_W +: REG_W]]) begin
                  raw = 1'b1;
               end
            end
            if (dst_we_i[l] && (cnt[dst_reg_i[l*REG_W +: REG_W]] > lat_i[l*LAT_W +: LAT_W])) begin
               waw = 1'b1;
            end
            if (ucnt_nz[l]) begin
               strct = 1'b1;
            end
         end
      end
   end

   assign bundle_live    = issue_valid_i && !flush_i;
   assign stall_o        = bundle_live && (raw || waw || strct);
   assign issue_o        = bundle_live && !stall_o;
   assign stall_cycles_o = perf;

   // Ascending lane order lets the highest-index writer of a shared dst win.
   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         reg_load[r] = 1'b0;
         reg_val[r]  = '0;
      end
      lane_load = '0;
      if (issue_o) begin
         for (int l = 0; l < NLANES; l++) begin
            if (lane_valid_i[l] && dst_we_i[l] && (dst_reg_i[l*REG_W +: REG_W] != '0) &&
                (lat_i[l*LAT_W +: LAT_W] != '0)) begin
               reg_load[dst_reg_i[l*REG_W +: REG_W]] = 1'b1;
               reg_val[dst_reg_i[l*REG_W +: REG_W]]  = lat_i[l*LAT_W +: LAT_W];
            end
            lane_load[l] = lane_valid_i[l] && unpipelined_i[l] && (lat_i[l*LAT_W +: LAT_W] != '0);
         end
      end
   end

   always_comb begin
      for (int l = 0; l < NLANES; l++) begin
         assert (ucnt_nz[l] == (ucnt[l] != '0));
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         perf <= '0;
      end else if (stall_o && (perf != '1)) begin
         perf <= perf + 1'b1;
      end
   end

endmodule

// File: tb/tb_fpu_scoreboard_vliw.sv
// Directed bench for fpu_scoreboard_vliw: hand-timed bundles for RAW, WAW,
// structural, r0, flush, same-dst, max-latency and mid-run reset cases.
module tb_fpu_scoreboard_vliw;

   localparam int NL = 4;
   localparam int NR = 64;
   localparam int RW = 6;
   localparam int LW = 5;
   localparam int PW = 4;

   logic              clk;
   logic              rstn;
   logic              issue_valid;
   logic              flush;
   logic [NL-1:0]     lane_valid;
   logic [NL*2*RW-1:0] src_reg;
   logic [NL*2-1:0]   src_use;
   logic [NL*RW-1:0]  dst_reg;
   logic [NL-1:0]     dst_we;
   logic [NL*LW-1:0]  lat;
   logic [NL-1:0]     unpipelined;
   logic              stall;
   logic              issue;
   logic [NR-1:0]     pending;
   logic [PW-1:0]     stall_cycles;

   int assertions = 0;
   int failures   = 0;
   int exp_perf   = 0;

   fpu_scoreboard_vliw #(
      .NLANES(NL), .NREG(NR), .LAT_W(LW), .PERF_W(PW)
   ) dut (
      .clk            (clk),
      .rstn           (rstn),
      .issue_valid_i  (issue_valid),
      .flush_i        (flush),
      .lane_valid_i   (lane_valid),
      .src_reg_i      (src_reg),
      .src_use_i      (src_use),
      .dst_reg_i      (dst_reg),
      .dst_we_i       (dst_we),
      .lat_i          (lat),
      .unpipelined_i  (unpipelined),
      .stall_o        (stall),
      .issue_o        (issue),
      .pending_o      (pending),
      .stall_cycles_o (stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      assertions++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus();
      #1;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clearBundle();
      issue_valid = 1'b1;
      flush       = 1'b0;
      lane_valid  = '0;
      src_reg     = '0;
      src_use     = '0;
      dst_reg     = '0;
      dst_we      = '0;
      lat         = '0;
      unpipelined = '0;
   endtask

   task automatic setRead(input int lane, input int slot, input int r);
      lane_valid[lane]                = 1'b1;
      src_reg[(lane*2+slot)*RW +: RW] = RW'(r);
      src_use[lane*2+slot]            = 1'b1;
   endtask

   task automatic setWrite(input int lane, input int r, input int l, input bit unp);
      lane_valid[lane]       = 1'b1;
      dst_reg[lane*RW +: RW] = RW'(r);
      dst_we[lane]           = 1'b1;
      lat[lane*LW +: LW]     = LW'(l);
      unpipelined[lane]      = unp;
   endtask

   task automatic expectCycle(input string tag, input bit exp_stall, input bit exp_issue);
      checkOutput({tag, "_stall"}, stall, exp_stall);
      checkOutput({tag, "_issue"}, issue, exp_issue);
      if (exp_stall && exp_perf != 15) exp_perf++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         nextCycle();
         clearBundle();
         issue_valid = 1'b0;
      end
   endtask

   initial begin
      rstn = 1'b0;
      clearBundle();
      issue_valid = 1'b0;
      repeat (3) nextCycle();
      rstn = 1'b1;
      applyStimulus();
      checkOutput("rst_stall", stall, 0);
      checkOutput("rst_issue", issue, 0);
      checkOutput("rst_pending", pending, 0);
      checkOutput("rst_perf", stall_cycles, 0);
      issue_valid = 1'b1;
      applyStimulus();
      checkOutput("rst_empty_issue", issue, 1);

      // Load-use RAW
      nextCycle(); clearBundle(); setWrite(1, 5, 1, 0); applyStimulus();
      expectCycle("lu_prod", 0, 1);
      nextCycle(); clearBundle(); setRead(0, 0, 5); applyStimulus();
      checkOutput("lu_pend_t1", pending[5], 1);
      expectCycle("lu_t1", 1, 0);
      nextCycle(); clearBundle(); setRead(0, 0, 5); applyStimulus();
      checkOutput("lu_pend_t2", pending[5], 0);
      expectCycle("lu_t2", 0, 1);
      idle(1);
      checkOutput("lu_perf", stall_cycles, exp_perf);

      // fdiv structural hazard on lane0
      nextCycle(); clearBundle(); setWrite(0, 10, 3, 1); applyStimulus();
      expectCycle("st_div", 0, 1);
      for (int i = 0; i < 3; i++) begin
         nextCycle(); clearBundle(); setWrite(0, 11, 0, 0); applyStimulus();
         expectCycle("st_wait", 1, 0);
      end
      nextCycle(); clearBundle(); setWrite(0, 11, 0, 0); applyStimulus();
      expectCycle("st_t4", 0, 1);
      nextCycle(); clearBundle(); setWrite(0, 10, 3, 1); applyStimulus();
      expectCycle("st_div2", 0, 1);
      nextCycle(); clearBundle(); setWrite(2, 11, 0, 0); applyStimulus();
      expectCycle("st_lane2", 0, 1);
      idle(4);
      checkOutput("st_perf", stall_cycles, exp_perf);

      // WAW: ALU overwrite waits, fsqrt with equal latency does not
      nextCycle(); clearBundle(); setWrite(1, 8, 3, 1); applyStimulus();
      expectCycle("waw_div", 0, 1);
      for (int i = 0; i < 3; i++) begin
         nextCycle(); clearBundle(); setWrite(0, 8, 0, 0); applyStimulus();
         expectCycle("waw_wait", 1, 0);
      end
      nextCycle(); clearBundle(); setWrite(0, 8, 0, 0); applyStimulus();
      expectCycle("waw_t4", 0, 1);
      idle(1);
      nextCycle(); clearBundle(); setWrite(1, 8, 3, 1); applyStimulus();
      expectCycle("waw_div2", 0, 1);
      nextCycle(); clearBundle(); setWrite(2, 8, 3, 1); applyStimulus();
      expectCycle("waw_sqrt", 0, 1);
      for (int i = 0; i < 3; i++) begin
         nextCycle(); clearBundle(); setRead(0, 0, 8); applyStimulus();
         expectCycle("waw_reload", 1, 0);
      end
      nextCycle(); clearBundle(); setRead(0, 0, 8); applyStimulus();
      expectCycle("waw_reader", 0, 1);
      idle(4);

      // r0 never pending; flush masks a live RAW hazard
      nextCycle(); clearBundle(); setWrite(0, 0, 3, 0); applyStimulus();
      expectCycle("r0_wr", 0, 1);
      nextCycle(); clearBundle(); setRead(0, 0, 0); setRead(0, 1, 0); applyStimulus();
      checkOutput("r0_pending", pending, 0);
      expectCycle("r0_rd", 0, 1);
      nextCycle(); clearBundle(); setWrite(1, 12, 2, 0); applyStimulus();
      expectCycle("fl_prod", 0, 1);
      nextCycle(); clearBundle(); setRead(0, 0, 12); flush = 1'b1; applyStimulus();
      checkOutput("fl_pend", pending[12], 1);
      expectCycle("fl_flush", 0, 0);
      nextCycle(); clearBundle(); setRead(0, 0, 12); applyStimulus();
      expectCycle("fl_t2", 1, 0);
      nextCycle(); clearBundle(); setRead(0, 0, 12); applyStimulus();
      expectCycle("fl_t3", 0, 1);
      idle(1);
      checkOutput("fl_perf", stall_cycles, exp_perf);

      // Same dst in two lanes: lane3 latency wins
      nextCycle(); clearBundle(); setWrite(0, 9, 1, 0); setWrite(3, 9, 3, 0); applyStimulus();
      expectCycle("sd_prod", 0, 1);
      for (int i = 0; i < 3; i++) begin
         nextCycle(); clearBundle(); setRead(1, 1, 9); applyStimulus();
         expectCycle("sd_wait", 1, 0);
      end
      nextCycle(); clearBundle(); setRead(1, 1, 9); applyStimulus();
      expectCycle("sd_issue", 0, 1);
      idle(2);

      // Maximum latency without wrap; perf saturates at 4 bits
      nextCycle(); clearBundle(); setWrite(2, 30, 31, 0); applyStimulus();
      expectCycle("max_prod", 0, 1);
      for (int i = 0; i < 31; i++) begin
         nextCycle(); clearBundle(); setRead(3, 0, 30); applyStimulus();
         expectCycle("max_wait", 1, 0);
      end
      nextCycle(); clearBundle(); setRead(3, 0, 30); applyStimulus();
      expectCycle("max_issue", 0, 1);
      idle(1);
      checkOutput("max_perf_sat", stall_cycles, 15);

      // Reset while entries are pending
      nextCycle(); clearBundle(); setWrite(0, 20, 5, 0); setWrite(1, 21, 4, 0); applyStimulus();
      expectCycle("mr_prod", 0, 1);
      nextCycle(); clearBundle(); setRead(2, 0, 20); applyStimulus();
      expectCycle("mr_blocked", 1, 0);
      rstn = 1'b0;
      exp_perf = 0;
      nextCycle(); clearBundle(); setRead(2, 0, 20); applyStimulus();
      checkOutput("mr_pending", pending, 0);
      checkOutput("mr_perf", stall_cycles, 0);
      expectCycle("mr_after", 0, 1);
      rstn = 1'b1;
      idle(1);
      checkOutput("mr_perf_hold", stall_cycles, exp_perf);

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule

// File: doc/fpu_scoreboard_vliw.md
# fpu_scoreboard_vliw

Parametrised register scoreboard and interlock for the VLIW decode stage. It tracks every in-flight multi-cycle write (FPU, loads) with a per-register countdown. It stalls the decode bundle on RAW, WAW and structural (unpipelined unit) hazards. It replaces the fixed per-opcode stall counters with a latency-driven, N-lane, N-register design.

## Interface
Parameters:
- NLANES, 4: issue slots per bundle.
- NREG, 64: architectural registers; REG_W = $clog2(NREG).
- LAT_W, 5: latency counter width; max latency 2^LAT_W-1.
- PERF_W, 32: stall counter width.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous, active-low reset
- issue_valid_i  in  1  decode bundle present
- flush_i  in  1  kill decode bundle this cycle (branch/jr redirect)
- lane_valid_i  in  NLANES  lane holds a real op
- src_reg_i  in  NLANES*2*REG_W  rs/rt per lane (lane l: bits [l*2*REG_W +: 2*REG_W], rs low)
- src_use_i  in  NLANES*2  operand actually read
- dst_reg_i  in  NLANES*REG_W  destination per lane
- dst_we_i  in  NLANES  lane writes dst
- lat_i  in  NLANES*LAT_W  extra cycles until result forwardable (0 = plain ALU)
- unpipelined_i  in  NLANES  op occupies its lane unit for lat cycles (fdiv, fsqrt)
- stall_o  out  1  hold F/D, bubble into E
- issue_o  out  1  bundle fires this cycle
- pending_o  out  NREG  bit r = cnt[r] != 0
- stall_cycles_o  out  PERF_W  saturating count of stalled cycles

## Operation
- State: cnt[r] (LAT_W) for r=1..NREG-1; cnt[0] is hard-wired 0. ucnt[l] (LAT_W) per lane. perf counter.
- raw: some lane has lane_valid && src_use && src!=0 && cnt[src]!=0.
- waw: some lane has lane_valid && dst_we && dst!=0 && cnt[dst] > lat of that lane.
- struct: some lane has lane_valid && ucnt[l]!=0.
- stall_o = issue_valid_i && !flush_i && (raw||waw||struct).
- issue_o = issue_valid_i && !flush_i && !stall_o.
- Every cycle, nonzero cnt and ucnt decrement by 1.
- On issue_o, for each lane with lane_valid && dst_we && dst!=0 && lat!=0: cnt[dst] <= lat. This overrides the decrement. Zero-latency writes create no entry.
- On issue_o, for each lane with lane_valid && unpipelined && lat!=0: ucnt[l] <= lat.
- Two lanes writing the same dst in one bundle: the higher-index lane's lat is loaded.
- Intra-bundle reads see pre-bundle values, so they are never a hazard.
- flush_i suppresses issue and stall. Already-issued entries keep counting down and are not cancelled.
- perf: increments on each stall_o cycle and saturates at all-ones.

## Timing
- stall_o, issue_o and pending_o are combinational from inputs and state. State updates on the posedge.
- Producer issues at cycle t with lat=L. A dependent bundle issues no earlier than t+1+L; L=0 gives back-to-back issue.
- An unpipelined op with lat=L blocks its lane from t+1 to t+L; the lane issues at t+1+L.
- Reset (also mid-operation): all cnt, ucnt and perf go to 0 on the next edge. Outputs then read stall_o=0, issue_o=issue_valid_i&&!flush_i, pending_o=0, stall_cycles_o=0.
- Max latency 2^LAT_W-1 must be supported without wrap. Counters never underflow below 0.

## Structure
- Package fpu_sb_pkg holds:
  - NLANES/NREG/LAT_W defaults.
  - Op latencies: LAT_ALU=0, LAT_LW=1, LAT_FADD=1, LAT_FSUB=1, LAT_FMUL=1, LAT_FSQRT=2, LAT_FDIV=3. Others are 0.
- Sub-module sb_countdown (LAT_W): load/value/decrement/nonzero. Instantiate it NREG-1 times for cnt and NLANES times for ucnt.

## Test plan
- Load-use RAW: lane1 writes r5 with lat=1 at t, and the next bundle lane0 reads r5. Expect stall_o=1 at t+1, issue_o=1 at t+2, pending_o[5]=1 only at t+1.
- fdiv structural hazard: lane0 unpipelined lat=3 at t, followed by a fresh independent lane0 op. Expect stall for 3 cycles and issue at t+4. A lane2-only independent bundle issues at t+1.
- WAW: fdiv r8 lat=3 at t, then an ALU write r8 lat=0 at t+1. Expect stall until cnt[8]=0 and issue at t+4. An fsqrt r8 lat=3 at t+1 (cnt 3 > 3 false) issues immediately and reloads cnt=3.
- r0 and flush: a write to r0 lat=3 followed by a read of r0 never stalls. flush_i during a RAW hazard gives stall_o=0 and issue_o=0, and cnt keeps decrementing.
- Same-dst lanes: lane0 r9 lat=1 and lane3 r9 lat=3 in one bundle. Expect cnt[9]=3 and a reader stalled 3 cycles.
- Reset mid-operation: assert rstn=0 with several cnt nonzero. The next cycle shows pending_o=0, stall_cycles_o=0, and a formerly blocked bundle issues.
